bitstream_byte_serializer: RTL and testbench
============================================

Name: bitstream_byte_serializer

Overview:
- Consumer end of the stage-4 carry-propagation output interface.
- Each cycle it accepts 0–5 finished bytes (lane 1 first), plus a byte count and a last flag.
- Bytes are buffered in a circular FIFO and emitted one byte per cycle on a valid/ready stream toward memory or the packetizer.
- Frame end is marked on the final byte, and a done pulse is issued when the frame has drained.

Parameters:
BS_BITSTREAM_WIDTH, 8, byte width of every lane and of the output
BS_FIFO_DEPTH, 16, FIFO entries; power of two, must be >= 8
BS_ADDR_WIDTH, 4, log2(BS_FIFO_DEPTH)
BS_COUNT_WIDTH, 24, width of the emitted-byte counter

Ports:
bs_clk  in  1  single clock, rising edge
bs_reset_n  in  1  asynchronous active-low reset
in_bit_1..in_bit_5  in  8 each  byte lanes; lane 1 is the oldest byte
in_flag_bitstream  in  3  number of valid lanes, 0..5
in_flag_last  in  1  final group of the frame (may carry 0 bytes)
in_ready  out  1  block can accept a 5-byte group this cycle
out_byte  out  8  head-of-FIFO byte
out_valid  out  1  out_byte valid
out_ready  in  1  downstream accepts out_byte
out_last  out  1  out_byte is the final byte of the frame
out_done  out  1  one-cycle pulse: frame fully emitted
out_byte_count  out  24  bytes emitted in current frame
out_overflow  out  1  sticky protocol error

Behaviour:
- Reset (asynchronous, active-low):
  - wr_ptr, rd_ptr, count, last_pending, byte counter and out_overflow all go to 0.
  - State goes to IDLE.
  - Outputs during reset: out_valid=0, out_last=0, out_done=0, in_ready=1.
  - FIFO contents are don't-care.
  - Reset mid-frame discards all buffered bytes.
- in_ready:
  - Combinational from registers only: (state is IDLE or STREAM) and (BS_FIFO_DEPTH - count >= 5).
  - No combinational path from any input to in_ready.
- Push:
  - Condition: in_flag_bitstream = n, 1 <= n <= 5, and in_ready = 1.
  - At the edge, lanes 1..n are written to fifo[wr_ptr .. wr_ptr+n-1], modulo depth, so pointers wrap.
  - wr_ptr advances by n. Lanes above n are ignored.
- Pop:
  - out_valid = (count != 0). out_byte = fifo[rd_ptr].
  - Pop occurs when out_valid & out_ready. rd_ptr advances by 1 and the byte counter increments.
  - A byte pushed at edge N shows out_valid=1 after edge N (latency 1 cycle).
- Simultaneous push and pop: count_next = count + n - 1.
- Overflow error:
  - in_flag_bitstream in 6..7, or n >= 1 while in_ready = 0: bytes are dropped and out_overflow is set.
  - out_overflow stays set until reset.
  - Other state is unaffected; the accompanying in_flag_last is still honoured.
- Last tracking:
  - On an accepted in_flag_last with n >= 1: last_ptr = wr_ptr + n - 1 and last_pending = 1.
  - out_last = out_valid & last_pending & (rd_ptr == last_ptr).
- State machine:
  - IDLE: count = 0 and no frame open. n >= 1 -> STREAM. in_flag_last with n = 0 -> DONE (empty frame, no out_last).
  - STREAM: in_flag_last seen (in a cycle where in_ready = 1, or on an error cycle) -> DRAIN.
  - DRAIN: in_ready = 0. The pop of the byte with out_last = 1 -> DONE.
  - DONE: out_done = 1 for exactly one cycle. last_pending and the byte counter clear -> IDLE.
  - in_flag_last with n = 0 in STREAM -> DRAIN, with last_ptr = wr_ptr - 1.
  - If count is already 0 when the DRAIN condition is met, go straight to DONE. In that case no byte carries out_last.
- out_byte_count:
  - Increments on each pop.
  - Holds its value through the out_done cycle, then reads 0 in IDLE.
  - Wraps modulo 2^24 without error.
- out_byte and out_last are held stable while out_valid & !out_ready.

Test Plan:
- Single group: reset, push n=3 bytes A1,B2,C3, out_ready=1 -> out_byte A1,B2,C3 on three consecutive cycles starting 1 cycle after the push; out_valid then drops; out_overflow=0.
- Backpressure/full: out_ready=0, push n=5 groups each cycle -> in_ready drops after 3 groups (count=15, free 1 < 5); a fourth push attempt sets out_overflow and count stays 15; raise out_ready -> 15 bytes emerge in order.
- Wrap plus simultaneous push/pop: sustained n=1 pushes with out_ready=1 for 40 cycles -> count stays 1; bytes emerge in order across pointer wrap; no in_ready drop.
- Frame end: push n=4 (11,22,33,44) with in_flag_last=1 -> out_last=1 only with 44; out_done pulses the cycle after 44 pops; out_byte_count=4 during the pulse, then 0; in_ready=0 during drain.
- Empty frame: from IDLE, in_flag_last=1 with n=0 -> out_done pulses one cycle later; out_last is never asserted; out_valid=0 throughout.
- Async reset mid-drain: with 6 bytes buffered, assert bs_reset_n=0 between clock edges -> out_valid=0 and in_ready=1 immediately; after release the FIFO is empty and the state is IDLE.

Source files
------------

// File: rtl/bitstream_byte_serializer.sv
// Byte serializer: accepts up to five bytes per cycle into a circular FIFO and
// emits them one per cycle on a valid/ready stream with frame-end tracking.
module bitstream_byte_serializer #(
  parameter int BS_BITSTREAM_WIDTH = 8,
  parameter int BS_FIFO_DEPTH      = 16,
  parameter int BS_ADDR_WIDTH      = 4,
  parameter int BS_COUNT_WIDTH     = 24
) (
  input  logic                          bs_clk,
  input  logic                          bs_reset_n,
  input  logic [BS_BITSTREAM_WIDTH-1:0] in_bit_1,
  input  logic [BS_BITSTREAM_WIDTH-1:0] in_bit_2,
  input  logic [BS_BITSTREAM_WIDTH-1:0] in_bit_3,
  input  logic [BS_BITSTREAM_WIDTH-1:0] in_bit_4,
  input  logic [BS_BITSTREAM_WIDTH-1:0] in_bit_5,
  input  logic [2:0]                    in_flag_bitstream,
  input  logic                          in_flag_last,
  output logic                          in_ready,
  output logic [BS_BITSTREAM_WIDTH-1:0] out_byte,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          out_done,
  output logic [BS_COUNT_WIDTH-1:0]     out_byte_count,
  output logic                          out_overflow
);

  localparam int CW = BS_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t                        r_state;
  logic [BS_ADDR_WIDTH-1:0]      r_wr_ptr;
  logic [BS_ADDR_WIDTH-1:0]      r_rd_ptr;
  logic [BS_ADDR_WIDTH-1:0]      r_last_ptr;
  logic [CW-1:0]                 r_count;
  logic                          r_last_pending;
  logic                          r_overflow;
  logic [BS_COUNT_WIDTH-1:0]     r_byte_cnt;
  logic [BS_BITSTREAM_WIDTH-1:0] r_fifo [BS_FIFO_DEPTH];

  logic                          w_open;
  logic                          w_bad_n;
  logic                          w_push;
  logic                          w_err;
  logic                          w_pop;
  logic                          w_last_acc;
  logic [2:0]                    w_n_acc;
  logic [BS_ADDR_WIDTH-1:0]      w_n_ext;
  logic [BS_ADDR_WIDTH-1:0]      w_last_ptr_next;
  logic [CW-1:0]                 w_count_next;
  logic [BS_BITSTREAM_WIDTH-1:0] w_lanes     [5];
  logic [BS_ADDR_WIDTH-1:0]      w_lane_addr [5];
  logic                          w_lane_we   [5];

  assign w_open   = (r_state == S_IDLE) || (r_state == S_STREAM);
  assign in_ready = w_open && (r_count <= CW'(BS_FIFO_DEPTH - 5));

  assign w_bad_n    = in_flag_bitstream > 3'd5;
  assign w_push     = !w_bad_n && (in_flag_bitstream != 3'd0) && in_ready;
  assign w_err      = w_bad_n || ((in_flag_bitstream != 3'd0) && !in_ready);
  assign w_n_acc    = w_push ? in_flag_bitstream : 3'd0;
  assign w_n_ext    = BS_ADDR_WIDTH'(w_n_acc);
  assign w_pop      = out_valid && out_ready;
  // A last flag closes the frame whether the group was accepted, empty or dropped.
  assign w_last_acc = in_flag_last && w_open;

  assign w_count_next    = r_count + CW'(w_n_acc) - CW'(w_pop);
  assign w_last_ptr_next = r_wr_ptr + w_n_ext - BS_ADDR_WIDTH'(1);

  assign w_lanes[0] = in_bit_1;
  assign w_lanes[1] = in_bit_2;
  assign w_lanes[2] = in_bit_3;
  assign w_lanes[3] = in_bit_4;
  assign w_lanes[4] = in_bit_5;

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_lane
      assign w_lane_we[gi]   = w_push && (in_flag_bitstream > 3'(gi));
      assign w_lane_addr[gi] = r_wr_ptr + BS_ADDR_WIDTH'(gi);
    end
  endgenerate

  always_ff @(posedge bs_clk) begin
    for (int i = 0; i < 5; i++) begin
      if (w_lane_we[i]) r_fifo[w_lane_addr[i]] <= w_lanes[i];
    end
  end

  assign out_valid      = (r_count != '0);
  assign out_byte       = r_fifo[r_rd_ptr];
  assign out_last       = out_valid && r_last_pending && (r_rd_ptr == r_last_ptr);
  assign out_done       = (r_state == S_DONE);
  assign out_byte_count = r_byte_cnt;
  assign out_overflow   = r_overflow;

  always_ff @(posedge bs_clk or negedge bs_reset_n) begin
    if (!bs_reset_n) begin
      r_state        <= S_IDLE;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_last_ptr     <= '0;
      r_count        <= '0;
      r_last_pending <= 1'b0;
      r_overflow     <= 1'b0;
      r_byte_cnt     <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_n_ext;
      r_count  <= w_count_next;
      if (w_pop) r_rd_ptr <= r_rd_ptr + BS_ADDR_WIDTH'(1);
      if (w_err) r_overflow <= 1'b1;

      if (r_state == S_DONE)  r_byte_cnt <= '0;
      else if (w_pop)         r_byte_cnt <= r_byte_cnt + BS_COUNT_WIDTH'(1);

      case (r_state)
        S_IDLE, S_STREAM: begin
          if (w_last_acc) begin
            r_last_ptr <= w_last_ptr_next;
            // Nothing left to drain means no byte can carry the frame-end mark.
            if (w_count_next == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state        <= S_DRAIN;
              r_last_pending <= 1'b1;
            end
          end else if ((r_state == S_IDLE) && w_push) begin
            r_state <= S_STREAM;
          end
        end
        S_DRAIN: begin
          if (w_pop && out_last) r_state <= S_DONE;
        end
        S_DONE: begin
          r_last_pending <= 1'b0;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitstream_byte_serializer.sv
// Directed bench for bitstream_byte_serializer: single group, backpressure,
// wrap with concurrent push/pop, frame end, empty frame and async reset.
module tb_bitstream_byte_serializer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  b1, b2, b3, b4, b5;
  logic [2:0]  n;
  logic        last;
  logic        in_ready;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        out_done;
  logic [23:0] out_byte_count;
  logic        out_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  bitstream_byte_serializer dut (
    .bs_clk            (clk),
    .bs_reset_n        (rst_n),
    .in_bit_1          (b1),
    .in_bit_2          (b2),
    .in_bit_3          (b3),
    .in_bit_4          (b4),
    .in_bit_5          (b5),
    .in_flag_bitstream (n),
    .in_flag_last      (last),
    .in_ready          (in_ready),
    .out_byte          (out_byte),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_last          (out_last),
    .out_done          (out_done),
    .out_byte_count    (out_byte_count),
    .out_overflow      (out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] nn, input logic ll,
                       input logic [7:0] x1, input logic [7:0] x2, input logic [7:0] x3,
                       input logic [7:0] x4, input logic [7:0] x5);
    n = nn; last = ll; b1 = x1; b2 = x2; b3 = x3; b4 = x4; b5 = x5;
  endtask

  task automatic do_reset();
    drive(3'd0, 1'b0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
    out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(3'd0, 1'b0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
    #12;
    check("rst_valid",    32'(out_valid), 32'd0);
    check("rst_last",     32'(out_last), 32'd0);
    check("rst_done",     32'(out_done), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_ovf",      32'(out_overflow), 32'd0);
    check("rst_cnt",      32'(out_byte_count), 32'd0);

    // Single group of three bytes
    do_reset();
    out_ready = 1'b1;
    drive(3'd3, 1'b0, 8'hA1, 8'hB2, 8'hC3, 8'h55, 8'h66);
    tick();
    drive(3'd0, 1'b0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
    check("g1_v0", 32'(out_valid), 32'd1);
    check("g1_b0", 32'(out_byte), 32'hA1);
    tick();
    check("g1_b1", 32'(out_byte), 32'hB2);
    tick();
    check("g1_b2", 32'(out_byte), 32'hC3);
    tick();
    check("g1_vend", 32'(out_valid), 32'd0);
    check("g1_ovf",  32'(out_overflow), 32'd0);
    check("g1_cnt",  32'(out_byte_count), 32'd3);

    // Backpressure until full, then overflow attempt, then drain
    do_reset();
    out_ready = 1'b0;
    for (int g = 0; g < 3; g++) begin
      drive(3'd5, 1'b0, 8'(8'h10 + 5*g), 8'(8'h11 + 5*g), 8'(8'h12 + 5*g),
            8'(8'h13 + 5*g), 8'(8'h14 + 5*g));
      tick();
      check($sformatf("bp_in_ready_g%0d", g), 32'(in_ready), (g < 2) ? 32'd1 : 32'd0);
    end
    drive(3'd5, 1'b0, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE);
    tick();
    drive(3'd0, 1'b0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
    check("bp_ovf",      32'(out_overflow), 32'd1);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 15; k++) begin
      check($sformatf("bp_byte%0d", k), 32'(out_byte), 32'(8'h10 + k));
      tick();
    end
    check("bp_empty", 32'(out_valid), 32'd0);
    check("bp_cnt",   32'(out_byte_count), 32'd15);
    check("bp_ovf_sticky", 32'(out_overflow), 32'd1);

    // Sustained single-byte push with concurrent pop, across pointer wrap
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      drive(3'd1, 1'b0, 8'(8'h40 + i), 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      tick();
      check($sformatf("wr_byte%0d", i), 32'(out_byte), 32'(8'h40 + i));
      check($sformatf("wr_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("wr_rdy%0d", i), 32'(in_ready), 32'd1);
    end
    drive(3'd0, 1'b0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
    tick();
    check("wr_empty", 32'(out_valid), 32'd0);
    check("wr_ovf",   32'(out_overflow), 32'd0);

    // Frame end with four bytes
    do_reset();
    out_ready = 1'b1;
    drive(3'd4, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h99);
    tick();
    drive(3'd0, 1'b0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
    check("fe_in_ready", 32'(in_ready), 32'd0);
    check("fe_b0", 32'(out_byte), 32'h11);
    check("fe_l0", 32'(out_last), 32'd0);
    tick();
    check("fe_b1", 32'(out_byte), 32'h22);
    check("fe_l1", 32'(out_last), 32'd0);
    tick();
    check("fe_b2", 32'(out_byte), 32'h33);
    check("fe_l2", 32'(out_last), 32'd0);
    tick();
    check("fe_b3",   32'(out_byte), 32'h44);
    check("fe_l3",   32'(out_last), 32'd1);
    check("fe_done0", 32'(out_done), 32'd0);
    tick();
    check("fe_done",  32'(out_done), 32'd1);
    check("fe_cnt",   32'(out_byte_count), 32'd4);
    check("fe_valid", 32'(out_valid), 32'd0);
    tick();
    check("fe_done_end", 32'(out_done), 32'd0);
    check("fe_cnt_clr",  32'(out_byte_count), 32'd0);
    check("fe_idle_rdy", 32'(in_ready), 32'd1);

    // Empty frame from IDLE
    do_reset();
    out_ready = 1'b1;
    drive(3'd0, 1'b1, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
    check("ef_valid_pre", 32'(out_valid), 32'd0);
    tick();
    drive(3'd0, 1'b0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
    check("ef_done",  32'(out_done), 32'd1);
    check("ef_valid", 32'(out_valid), 32'd0);
    check("ef_last",  32'(out_last), 32'd0);
    tick();
    check("ef_done_end", 32'(out_done), 32'd0);
    check("ef_valid2",   32'(out_valid), 32'd0);

    // Out-of-range lane count
    do_reset();
    drive(3'd6, 1'b0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
    tick();
    drive(3'd0, 1'b0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
    check("bad_n_ovf",   32'(out_overflow), 32'd1);
    check("bad_n_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset while draining six bytes
    do_reset();
    out_ready = 1'b0;
    drive(3'd5, 1'b0, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75);
    tick();
    drive(3'd1, 1'b1, 8'h76, 8'h0, 8'h0, 8'h0, 8'h0);
    tick();
    drive(3'd0, 1'b0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
    check("ar_drain_rdy", 32'(in_ready), 32'd0);
    check("ar_valid_pre", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_rdy",   32'(in_ready), 32'd1);
    check("ar_last",  32'(out_last), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_empty", 32'(out_valid), 32'd0);
    check("ar_done",  32'(out_done), 32'd0);
    check("ar_cnt",   32'(out_byte_count), 32'd0);
    out_ready = 1'b1;
    drive(3'd2, 1'b0, 8'h81, 8'h82, 8'h0, 8'h0, 8'h0);
    tick();
    drive(3'd0, 1'b0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
    check("ar_new_b0", 32'(out_byte), 32'h81);
    tick();
    check("ar_new_b1", 32'(out_byte), 32'h82);
    tick();
    check("ar_new_empty", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
